// File: rtl/weight_loader.sv
// Byte-serial weight RAM loader: parses A5/count/word frames and emits registered RAM writes.
// Optional trailing XOR checksum byte is enabled by defining WEIGHT_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module weight_loader #(
  parameter int NUM_WORDS = 128,
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 10
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              WE,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_FIN,
    S_ERR
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  localparam logic [8:0] MAX_N = 9'(NUM_WORDS);

  state_t            state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [8:0]        idx_q, idx_d;
  logic [1:0]        hi_q, hi_d;
  logic              rdy_q, rdy_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              acc;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign acc = byte_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (acc && byte_in == 8'hA5) begin
          state_d = S_COUNT;
          err_d   = 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      S_COUNT: begin
        if (acc) begin
          if (byte_in == 8'h00 || {1'b0, byte_in} > MAX_N) begin
            state_d = S_ERR;
          end else begin
            cnt_d   = {1'b0, byte_in};
            idx_d   = 9'd0;
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        if (acc) begin
          if (|byte_in[7:2]) begin
            state_d = S_ERR;
          end else begin
            hi_d    = byte_in[1:0];
            state_d = S_LO;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            csum_d  = csum_q ^ byte_in;
`endif
          end
        end
      end
      S_LO: begin
        if (acc) begin
          // Write is registered: WE/address/wdata appear the cycle after the LO byte.
          we_d    = 1'b1;
          addr_d  = idx_q[ADDR_W-1:0];
          wdata_d = DATA_W'({hi_q, byte_in});
          idx_d   = idx_q + 9'd1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ byte_in;
          state_d = (idx_q + 9'd1 == cnt_q) ? S_CSUM : S_HI;
`else
          state_d = (idx_q + 9'd1 == cnt_q) ? S_FIN : S_HI;
`endif
        end
      end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (acc) begin
          state_d = (byte_in == csum_q) ? S_FIN : S_ERR;
        end
      end
`endif
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ERR) begin
      err_d = 1'b1;
    end
    rdy_d = (state_d != S_FIN) && (state_d != S_ERR);
  end

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign byte_ready = rdy_q;
  assign WE         = we_q;
  assign address    = addr_q;
  assign wdata      = wdata_q;
  assign err        = err_q;
  assign done       = (state_q == S_FIN);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  assign busy       = (state_q == S_COUNT) || (state_q == S_HI) ||
                      (state_q == S_LO) || (state_q == S_CSUM);
`else
  assign busy       = (state_q == S_COUNT) || (state_q == S_HI) || (state_q == S_LO);
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader; frames carry a checksum byte only when WEIGHT_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_weight_loader;

  logic       Clock = 1'b0;
  logic       Rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       WE;
  logic [6:0] address;
  logic [9:0] wdata;
  logic       busy;
  logic       done;
  logic       err;

  always #5 Clock = ~Clock;

  weight_loader #(.NUM_WORDS(128), .ADDR_W(7), .DATA_W(10)) dut (
    .Clock(Clock), .Rst(Rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .WE(WE), .address(address), .wdata(wdata),
    .busy(busy), .done(done), .err(err)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [6:0] wa_q[$];
  logic [9:0] wd_q[$];
  int         done_cnt, coinc, rdy_low, rdy_low_fin;
  int         gap = 0;
  logic [7:0] fx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; observations are taken 1ns after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
    if (WE === 1'b1) begin
      wa_q.push_back(address);
      wd_q.push_back(wdata);
      if (done === 1'b1) coinc++;
    end
    if (done === 1'b1) done_cnt++;
    if (byte_ready === 1'b0) begin
      rdy_low++;
      if (done === 1'b1) rdy_low_fin++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0; coinc = 0; rdy_low = 0; rdy_low_fin = 0;
  endtask

  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) begin
      n_vec++;
      assert (guard < 20) else begin
        n_err++;
        $error("FAIL ready_timeout: observed byte_ready %b expected 1", byte_ready);
      end
    end
    tick();
    byte_valid = 1'b0;
    idle(gap);
  endtask

  task automatic start(input logic [7:0] n);
    fx = 8'h00;
    send(8'hA5);
    send(n);
  endtask

  task automatic sendw(input logic [7:0] hi, input logic [7:0] lo);
    fx ^= hi;
    send(hi);
    fx ^= lo;
    send(lo);
  endtask

  task automatic finish_frame();
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    send(fx);
`endif
    idle(2);
  endtask

  initial begin
    int bad;
    Rst = 1'b0;
    byte_in = 8'h00;
    byte_valid = 1'b0;
    clear_log();
    idle(2);
    chk("rst_ready", byte_ready, 0);
    chk("rst_we", WE, 0);
    chk("rst_addr", address, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    Rst = 1'b1;
    idle(1);

    // Good 3-word frame
    clear_log();
    start(8'h03);
    chk("t1_busy_mid", busy, 1);
    sendw(8'h00, 8'h01);
    sendw(8'h00, 8'h02);
    sendw(8'h03, 8'hFF);
    finish_frame();
    chk("t1_nwr", wa_q.size(), 3);
    chk("t1_a0", wa_q[0], 0);
    chk("t1_d0", wd_q[0], 10'h001);
    chk("t1_a1", wa_q[1], 1);
    chk("t1_d1", wd_q[1], 10'h002);
    chk("t1_a2", wa_q[2], 2);
    chk("t1_d2", wd_q[2], 10'h3FF);
    chk("t1_done", done_cnt, 1);
    chk("t1_err", err, 0);
    chk("t1_busy", busy, 0);
`ifndef WEIGHT_LOADER_CHECKSUM_EN
    chk("t1_done_with_we", coinc, 1);
`endif

    // Errored frame after partial writes, then a good frame clears err
    clear_log();
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    start(8'h03);
    sendw(8'h00, 8'h01);
    sendw(8'h00, 8'h02);
    sendw(8'h03, 8'hFF);
    send(8'h00);
    idle(2);
    chk("t2_nwr", wa_q.size(), 3);
`else
    start(8'h02);
    sendw(8'h00, 8'h05);
    send(8'h07);
    idle(2);
    chk("t2_nwr", wa_q.size(), 1);
`endif
    chk("t2_err", err, 1);
    chk("t2_done", done_cnt, 0);
    clear_log();
    start(8'h01);
    sendw(8'h02, 8'h11);
    finish_frame();
    chk("t2b_err", err, 0);
    chk("t2b_done", done_cnt, 1);
    chk("t2b_d0", wd_q[0], 10'h211);

    // Leading junk dropped; bad HI byte
    clear_log();
    send(8'h12);
    send(8'h34);
    idle(1);
    chk("t3_junk_err", err, 0);
    chk("t3_junk_busy", busy, 0);
    send(8'hA5);
    chk("t3_hdr_busy", busy, 1);
    send(8'h01);
    send(8'h04);
    chk("t3_err_rise", err, 1);
    send(8'h00);
    idle(2);
    chk("t3_err_sticky", err, 1);
    chk("t3_nwr", wa_q.size(), 0);
    chk("t3_done", done_cnt, 0);

    // Count bounds
    clear_log();
    start(8'h00);
    chk("t4_cnt0_err", err, 1);
    chk("t4_cnt0_busy", busy, 0);
    idle(1);
    send(8'hA5);
    chk("t4_hdr_clr", err, 0);
    send(8'h81);
    chk("t4_cnt81_err", err, 1);
    idle(2);
    chk("t4_nwr", wa_q.size(), 0);
    chk("t4_done", done_cnt, 0);

    // Full 128-word frame
    clear_log();
    start(8'h80);
    for (int i = 0; i < 128; i++) sendw(8'h01, 8'h55);
    finish_frame();
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++)
      if (wa_q[i] !== 7'(i) || wd_q[i] !== 10'h155) bad++;
    chk("t4_full_nwr", wa_q.size(), 128);
    chk("t4_full_bad", bad, 0);
    chk("t4_full_last_a", wa_q[127], 127);
    chk("t4_full_done", done_cnt, 1);
    chk("t4_full_err", err, 0);

    // Reset in the middle of a frame, coinciding with a LO byte
    clear_log();
    start(8'h03);
    sendw(8'h00, 8'h01);
    sendw(8'h00, 8'h02);
    send(8'h03);
    Rst = 1'b0;
    byte_in = 8'hFF;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    chk("t5_we", WE, 0);
    chk("t5_addr", address, 0);
    chk("t5_wdata", wdata, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", byte_ready, 0);
    chk("t5_done", done, 0);
    chk("t5_err", err, 0);
    Rst = 1'b1;
    send(8'h03);
    send(8'hFF);
    send(8'h00);
    idle(2);
    chk("t5_nwr", wa_q.size(), 2);
    chk("t5_done_cnt", done_cnt, 0);
    chk("t5_busy_after", busy, 0);

    // byte_valid toggling every cycle
    clear_log();
    gap = 1;
    start(8'h02);
    sendw(8'h01, 8'h23);
    sendw(8'h02, 8'hAB);
    finish_frame();
    gap = 0;
    chk("t6_nwr", wa_q.size(), 2);
    chk("t6_a0", wa_q[0], 0);
    chk("t6_d0", wd_q[0], 10'h123);
    chk("t6_a1", wa_q[1], 1);
    chk("t6_d1", wd_q[1], 10'h2AB);
    chk("t6_done", done_cnt, 1);
    chk("t6_rdy_low", rdy_low, 1);
    chk("t6_rdy_low_fin", rdy_low_fin, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
